// File: rtl/uart_seq_pkg.sv
// Shared state and mode encodings for the UART message sequencer.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_GAP
    } state_t;

    localparam logic [1:0] MODE_IDLE     = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;
    localparam logic [1:0] MODE_ECHO     = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, head visible combinationally; push while full is
// ignored unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/uart_msg_seq.sv
// Drives a uart core from a writable message buffer (periodic / one-shot) or echoes received bytes.
// Bytes go back-to-back, paced only by is_transmitting; a full echo FIFO drops bytes and sets a sticky flag.
module uart_msg_seq
    import uart_seq_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DELAY = 500000,
    parameter int CNT_W = 32,
    parameter int EAW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic [AW:0]   msg_len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic [7:0]    tx_byte,
    output logic          transmit,
    input  logic          is_transmitting,
    input  logic          received,
    input  logic [7:0]    rx_byte,
    output logic [7:0]    led,
    output logic          busy,
    output logic          msg_done,
    output logic          echo_overflow
);

    localparam int               MSG_DEPTH = 2**AW;
    localparam logic [AW:0]      DEPTH_L   = (AW+1)'(MSG_DEPTH);
    localparam logic [CNT_W-1:0] DELAY_L   = CNT_W'(DELAY);

    logic [7:0]       mem_q [MSG_DEPTH];
    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             src_echo_q, src_echo_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             transmit_q, transmit_d;
    logic [7:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             msg_done_q, msg_done_d;
    logic             overflow_q, overflow_d;

    logic [AW:0] len_clamp;
    logic        echo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_head;

    assign len_clamp = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
    assign echo_push = received && (mode == MODE_ECHO);
    assign fifo_pop  = (state_q == ST_SEND) && src_echo_q;

    sync_fifo #(.W(8), .AW(EAW)) u_echo_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (echo_push),
        .push_dat (rx_byte),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        src_echo_d = src_echo_q;
        tx_byte_d  = tx_byte_q;
        transmit_d = 1'b0;
        msg_done_d = 1'b0;
        led_d      = received ? rx_byte : led_q;
        overflow_d = overflow_q | (echo_push && fifo_full && !fifo_pop);

        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_PERIODIC) begin
                    state_d = ST_GAP;
                    cnt_d   = DELAY_L;
                end else if (mode == MODE_ONESHOT && start) begin
                    len_d      = len_clamp;
                    idx_d      = '0;
                    src_echo_d = 1'b0;
                    if (len_clamp == '0) msg_done_d = 1'b1;
                    else                 state_d    = ST_SEND;
                end else if (mode == MODE_ECHO && !fifo_empty) begin
                    src_echo_d = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_byte_d  = src_echo_q ? fifo_head : mem_q[idx_q];
                transmit_d = 1'b1;
                state_d    = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (is_transmitting) state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!is_transmitting) begin
                    if (src_echo_q) begin
                        msg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if ({1'b0, idx_q} == len_q - 1'b1) begin
                        msg_done_d = 1'b1;
                        if (mode == MODE_PERIODIC) begin
                            state_d = ST_GAP;
                            cnt_d   = DELAY_L;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (mode == MODE_PERIODIC) begin
                    len_d      = len_clamp;
                    idx_d      = '0;
                    src_echo_d = 1'b0;
                    // An empty periodic message just waits out another gap.
                    if (len_clamp == '0) cnt_d   = DELAY_L;
                    else                 state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= DELAY_L;
            src_echo_q <= 1'b0;
            tx_byte_q  <= '0;
            transmit_q <= 1'b0;
            led_q      <= '0;
            busy_q     <= 1'b0;
            msg_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            src_echo_q <= src_echo_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            msg_done_q <= msg_done_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_byte       = tx_byte_q;
    assign transmit      = transmit_q;
    assign led           = led_q;
    assign busy          = busy_q;
    assign msg_done      = msg_done_q;
    assign echo_overflow = overflow_q;

endmodule
